ldm_stm_seq: RTL and testbench

- Decode-stage micro-op sequencer that expands one ARMv4 LDM/STM instruction into one single-register memory micro-op per cycle.
- Its outputs drive the memory and register fields of the ID/EX pipeline register: address operand, rd code, is_ldm and base writeback.
- Asserts o_busy to hold fetch/decode while the sequence runs.

---
 rtl/ldm_stm_seq.sv | 136 +++++++++++++
 tb/tb_ldm_stm_seq.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ldm_stm_seq.sv
// ldm_stm_seq: expands one ARMv4 LDM/STM into a stream of single-register
// memory micro-ops, one per accepted cycle, lowest register first at the
// lowest address, with the base writeback attached to the final micro-op.
module ldm_stm_seq #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [15:0]       i_reglist,
    input  logic [3:0]        i_rn_code,
    input  logic [ADDR_W-1:0] i_rn_val,
    input  logic              i_load,
    input  logic              i_pre,
    input  logic              i_up,
    input  logic              i_wback,
    input  logic              i_stall,
    output logic              o_busy,
    output logic              o_uop_vld,
    output logic [ADDR_W-1:0] o_addr,
    output logic [3:0]        o_rd_code,
    output logic              o_is_ldm,
    output logic              o_last,
    output logic              o_wb_vld,
    output logic [3:0]        o_wb_code,
    output logic [ADDR_W-1:0] o_wb_val
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DONE0 = 2'd2
    } state_t;

    state_t              state_q;
    logic [15:0]         mask_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   wbase_q;
    logic                load_q;
    logic [3:0]          rn_q;
    logic                wben_q;

    logic [4:0]          count_d;
    logic [ADDR_W-1:0]   fourN_d;
    logic [ADDR_W-1:0]   startAddr_d;
    logic [ADDR_W-1:0]   finalBase_d;
    logic                wben_d;
    logic [3:0]          rdIdx;
    logic                lastOne;
    logic                inXfer;

    // Number of registers in the incoming list.
    always_comb begin
        count_d = 5'd0;
        for (int i = 0; i < 16; i++) begin
            count_d = count_d + 5'(i_reglist[i]);
        end
    end

    // Start address and final base for the incoming instruction; the span
    // 4N is widened to the address width before any subtraction.
    always_comb begin
        fourN_d     = ADDR_W'({count_d, 2'b00});
        finalBase_d = i_up ? (i_rn_val + fourN_d) : (i_rn_val - fourN_d);
        case ({i_pre, i_up})
            2'b01:   startAddr_d = i_rn_val;
            2'b11:   startAddr_d = i_rn_val + ADDR_W'(4);
            2'b00:   startAddr_d = i_rn_val - fourN_d + ADDR_W'(4);
            default: startAddr_d = i_rn_val - fourN_d;
        endcase
        // A load that overwrites the base keeps the loaded value, so no writeback.
        wben_d = i_wback & ~(i_load & i_reglist[i_rn_code]);
    end

    // Lowest remaining register and whether it is the final one.
    always_comb begin
        rdIdx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (mask_q[i]) rdIdx = 4'(i);
        end
        lastOne = (mask_q != 16'd0) && ((mask_q & (mask_q - 16'd1)) == 16'd0);
    end

    // Sequencer state; everything freezes while downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mask_q  <= 16'd0;
            addr_q  <= '0;
            wbase_q <= '0;
            load_q  <= 1'b0;
            rn_q    <= 4'd0;
            wben_q  <= 1'b0;
        end else if (!i_stall) begin
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        if (count_d != 5'd0) begin
                            mask_q  <= i_reglist;
                            addr_q  <= startAddr_d;
                            wbase_q <= finalBase_d;
                            load_q  <= i_load;
                            rn_q    <= i_rn_code;
                            wben_q  <= wben_d;
                            state_q <= XFER;
                        end else begin
                            state_q <= DONE0;
                        end
                    end
                end
                XFER: begin
                    mask_q <= mask_q & (mask_q - 16'd1);
                    addr_q <= addr_q + ADDR_W'(4);
                    if (lastOne) state_q <= IDLE;
                end
                DONE0:   state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Micro-op fields are only driven while transferring, zero otherwise.
    always_comb begin
        inXfer    = (state_q == XFER);
        o_busy    = ((state_q == IDLE) & i_start) | inXfer | (state_q == DONE0);
        o_uop_vld = inXfer;
        o_addr    = inXfer ? addr_q : '0;
        o_rd_code = inXfer ? rdIdx : 4'd0;
        o_is_ldm  = inXfer & load_q;
        o_last    = inXfer & lastOne;
        o_wb_vld  = inXfer & lastOne & wben_q;
        o_wb_code = inXfer ? rn_q : 4'd0;
        o_wb_val  = inXfer ? wbase_q : '0;
    end

endmodule

// File: tb/tb_ldm_stm_seq.sv
// Directed bench for ldm_stm_seq: inputs change and outputs are checked on
// the falling clock edge, expected values are hand-computed constants.
module tb_ldm_stm_seq;

    logic        clk;
    logic        rst;
    logic        i_start;
    logic [15:0] i_reglist;
    logic [3:0]  i_rn_code;
    logic [31:0] i_rn_val;
    logic        i_load;
    logic        i_pre;
    logic        i_up;
    logic        i_wback;
    logic        i_stall;
    logic        o_busy;
    logic        o_uop_vld;
    logic [31:0] o_addr;
    logic [3:0]  o_rd_code;
    logic        o_is_ldm;
    logic        o_last;
    logic        o_wb_vld;
    logic [3:0]  o_wb_code;
    logic [31:0] o_wb_val;

    int checks = 0;
    int failures = 0;

    ldm_stm_seq #(.ADDR_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_start   (i_start),
        .i_reglist (i_reglist),
        .i_rn_code (i_rn_code),
        .i_rn_val  (i_rn_val),
        .i_load    (i_load),
        .i_pre     (i_pre),
        .i_up      (i_up),
        .i_wback   (i_wback),
        .i_stall   (i_stall),
        .o_busy    (o_busy),
        .o_uop_vld (o_uop_vld),
        .o_addr    (o_addr),
        .o_rd_code (o_rd_code),
        .o_is_ldm  (o_is_ldm),
        .o_last    (o_last),
        .o_wb_vld  (o_wb_vld),
        .o_wb_code (o_wb_code),
        .o_wb_val  (o_wb_val)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nextCycle();
        @(negedge clk);
    endtask

    // Checks every output; writeback code/value only when writeback is expected.
    task automatic checkOut(input string tag, input logic busy, input logic vld,
                            input logic [31:0] addr, input logic [3:0] rd,
                            input logic ldm, input logic last, input logic wbv,
                            input logic [3:0] wbCode, input logic [31:0] wbVal);
        chk({tag, ".busy"}, 32'(o_busy), 32'(busy));
        chk({tag, ".vld"},  32'(o_uop_vld), 32'(vld));
        chk({tag, ".addr"}, o_addr, addr);
        chk({tag, ".rd"},   32'(o_rd_code), 32'(rd));
        chk({tag, ".ldm"},  32'(o_is_ldm), 32'(ldm));
        chk({tag, ".last"}, 32'(o_last), 32'(last));
        chk({tag, ".wbv"},  32'(o_wb_vld), 32'(wbv));
        if (wbv) begin
            chk({tag, ".wbcode"}, 32'(o_wb_code), 32'(wbCode));
            chk({tag, ".wbval"},  o_wb_val, wbVal);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOut(tag, 1'b0, 1'b0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
        chk({tag, ".wbcode0"}, 32'(o_wb_code), 32'h0);
        chk({tag, ".wbval0"},  o_wb_val, 32'h0);
    endtask

    // Presents an instruction at the current falling edge and checks the
    // combinational busy it raises while still idle.
    task automatic applyStimulus(input string tag, input logic [15:0] list,
                                 input logic [3:0] rn, input logic [31:0] rnVal,
                                 input logic l, input logic p, input logic u,
                                 input logic w);
        i_reglist = list;
        i_rn_code = rn;
        i_rn_val  = rnVal;
        i_load    = l;
        i_pre     = p;
        i_up      = u;
        i_wback   = w;
        i_start   = 1'b1;
        #1;
        chk({tag, ".startbusy"}, 32'(o_busy), 32'h1);
        chk({tag, ".startvld"},  32'(o_uop_vld), 32'h0);
        nextCycle();
        i_start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; i_start = 1'b0; i_reglist = 16'h0; i_rn_code = 4'd0;
        i_rn_val = 32'h0; i_load = 1'b0; i_pre = 1'b0; i_up = 1'b0;
        i_wback = 1'b0; i_stall = 1'b0;
        repeat (2) nextCycle();
        rst = 1'b0;
        checkIdle("reset");

        // LDMIA r0!,{r1,r2,r5}
        applyStimulus("ldmia", 16'h0026, 4'd0, 32'h1000, 1'b1, 1'b0, 1'b1, 1'b1);
        checkOut("ldmia.u1", 1, 1, 32'h1000, 4'd1, 1, 0, 0, 4'd0, 32'h0);
        nextCycle();
        checkOut("ldmia.u2", 1, 1, 32'h1004, 4'd2, 1, 0, 0, 4'd0, 32'h0);
        nextCycle();
        checkOut("ldmia.u3", 1, 1, 32'h1008, 4'd5, 1, 1, 1, 4'd0, 32'h100C);
        nextCycle();
        checkIdle("ldmia.end");

        // STMDB r13!,{r4-r7,r14}
        applyStimulus("stmdb", 16'h40F0, 4'd13, 32'h2000, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOut("stmdb.u1", 1, 1, 32'h1FEC, 4'd4, 0, 0, 0, 4'd0, 32'h0);
        nextCycle();
        checkOut("stmdb.u2", 1, 1, 32'h1FF0, 4'd5, 0, 0, 0, 4'd0, 32'h0);
        nextCycle();
        checkOut("stmdb.u3", 1, 1, 32'h1FF4, 4'd6, 0, 0, 0, 4'd0, 32'h0);
        nextCycle();
        checkOut("stmdb.u4", 1, 1, 32'h1FF8, 4'd7, 0, 0, 0, 4'd0, 32'h0);
        nextCycle();
        checkOut("stmdb.u5", 1, 1, 32'h1FFC, 4'd14, 0, 1, 1, 4'd13, 32'h1FEC);
        nextCycle();
        checkIdle("stmdb.end");

        // IB and DA with writeback, then both without
        applyStimulus("ib", 16'h0009, 4'd4, 32'h100, 1'b1, 1'b1, 1'b1, 1'b1);
        checkOut("ib.u1", 1, 1, 32'h104, 4'd0, 1, 0, 0, 4'd0, 32'h0);
        nextCycle();
        checkOut("ib.u2", 1, 1, 32'h108, 4'd3, 1, 1, 1, 4'd4, 32'h108);
        nextCycle();
        applyStimulus("da", 16'h0009, 4'd4, 32'h100, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOut("da.u1", 1, 1, 32'hFC, 4'd0, 1, 0, 0, 4'd0, 32'h0);
        nextCycle();
        checkOut("da.u2", 1, 1, 32'h100, 4'd3, 1, 1, 1, 4'd4, 32'hF8);
        nextCycle();
        applyStimulus("ibnw", 16'h0009, 4'd4, 32'h100, 1'b1, 1'b1, 1'b1, 1'b0);
        checkOut("ibnw.u1", 1, 1, 32'h104, 4'd0, 1, 0, 0, 4'd0, 32'h0);
        nextCycle();
        checkOut("ibnw.u2", 1, 1, 32'h108, 4'd3, 1, 1, 0, 4'd0, 32'h0);
        nextCycle();
        applyStimulus("danw", 16'h0009, 4'd4, 32'h100, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOut("danw.u1", 1, 1, 32'hFC, 4'd0, 1, 0, 0, 4'd0, 32'h0);
        nextCycle();
        checkOut("danw.u2", 1, 1, 32'h100, 4'd3, 1, 1, 0, 4'd0, 32'h0);
        nextCycle();

        // LDMIA r2!,{r1,r2,r3}: base in list suppresses writeback
        applyStimulus("ldbase", 16'h000E, 4'd2, 32'h40, 1'b1, 1'b0, 1'b1, 1'b1);
        checkOut("ldbase.u1", 1, 1, 32'h40, 4'd1, 1, 0, 0, 4'd0, 32'h0);
        nextCycle();
        checkOut("ldbase.u2", 1, 1, 32'h44, 4'd2, 1, 0, 0, 4'd0, 32'h0);
        nextCycle();
        checkOut("ldbase.u3", 1, 1, 32'h48, 4'd3, 1, 1, 0, 4'd0, 32'h0);
        nextCycle();
        // Same list as STM still writes back
        applyStimulus("stbase", 16'h000E, 4'd2, 32'h40, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOut("stbase.u1", 1, 1, 32'h40, 4'd1, 0, 0, 0, 4'd0, 32'h0);
        nextCycle();
        checkOut("stbase.u2", 1, 1, 32'h44, 4'd2, 0, 0, 0, 4'd0, 32'h0);
        nextCycle();
        checkOut("stbase.u3", 1, 1, 32'h48, 4'd3, 0, 1, 1, 4'd2, 32'h4C);
        nextCycle();
        checkIdle("stbase.end");

        // Stall held three cycles on the second micro-op
        applyStimulus("stall", 16'h0026, 4'd0, 32'h3000, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOut("stall.u1", 1, 1, 32'h3000, 4'd1, 1, 0, 0, 4'd0, 32'h0);
        nextCycle();
        i_stall = 1'b1;
        checkOut("stall.u2a", 1, 1, 32'h3004, 4'd2, 1, 0, 0, 4'd0, 32'h0);
        nextCycle();
        checkOut("stall.u2b", 1, 1, 32'h3004, 4'd2, 1, 0, 0, 4'd0, 32'h0);
        nextCycle();
        checkOut("stall.u2c", 1, 1, 32'h3004, 4'd2, 1, 0, 0, 4'd0, 32'h0);
        nextCycle();
        i_stall = 1'b0;
        checkOut("stall.u2d", 1, 1, 32'h3004, 4'd2, 1, 0, 0, 4'd0, 32'h0);
        nextCycle();
        checkOut("stall.u3", 1, 1, 32'h3008, 4'd5, 1, 1, 0, 4'd0, 32'h0);
        nextCycle();
        checkIdle("stall.end");

        // Empty list: two busy cycles, no micro-op
        applyStimulus("empty", 16'h0000, 4'd1, 32'h500, 1'b1, 1'b0, 1'b1, 1'b1);
        checkOut("empty.d0", 1, 0, 32'h0, 4'd0, 0, 0, 0, 4'd0, 32'h0);
        nextCycle();
        checkIdle("empty.end");

        // Reset during the second micro-op, then a fresh instruction
        applyStimulus("rst", 16'h0026, 4'd0, 32'h1000, 1'b1, 1'b0, 1'b1, 1'b1);
        checkOut("rst.u1", 1, 1, 32'h1000, 4'd1, 1, 0, 0, 4'd0, 32'h0);
        nextCycle();
        checkOut("rst.u2", 1, 1, 32'h1004, 4'd2, 1, 0, 0, 4'd0, 32'h0);
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
        checkIdle("rst.after");
        nextCycle();
        checkIdle("rst.after2");
        applyStimulus("fresh", 16'h0026, 4'd0, 32'h5000, 1'b1, 1'b0, 1'b1, 1'b1);
        checkOut("fresh.u1", 1, 1, 32'h5000, 4'd1, 1, 0, 0, 4'd0, 32'h0);
        nextCycle();
        checkOut("fresh.u2", 1, 1, 32'h5004, 4'd2, 1, 0, 0, 4'd0, 32'h0);
        nextCycle();
        checkOut("fresh.u3", 1, 1, 32'h5008, 4'd5, 1, 1, 1, 4'd0, 32'h500C);
        nextCycle();
        checkIdle("fresh.end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
